// File: rtl/axi_mem_responder_pkg.sv
// Shared response codes and FSM state types for the BRAM-backed AXI4 responder.
package axi_mem_responder_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} t_wr_state;
    typedef enum logic {R_IDLE, R_BURST} t_rd_state;
endpackage

// File: rtl/axi_mem_skid_buffer.sv
// Two-entry valid/ready buffer for the R channel; the head entry drives the outputs directly.
module axi_mem_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop   = i_ready && (r_count != 2'd0);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign o_count = r_count;

    // The producer never pushes into a full buffer without a pop in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_valid, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst responder over a dual-port BRAM with independent write and read engines.
// Optional AXI_MEM_RESPONDER_STATS_EN adds saturating burst/error counters.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH     = 256,
    parameter int ADDR_WIDTH     = 42,
    parameter int ID_WIDTH       = 8,
    parameter int LEN_WIDTH      = 8,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [LEN_WIDTH-1:0]    i_awlen,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [1:0]              o_bresp,
    output logic [ID_WIDTH-1:0]     o_bid,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [LEN_WIDTH-1:0]    i_arlen,
    input  logic [ID_WIDTH-1:0]     i_arid,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic                    o_rlast
`ifdef AXI_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]             o_wr_bursts,
    output logic [31:0]             o_rd_bursts,
    output logic [15:0]             o_err_count
`endif
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int OFF = $clog2(BPB);
    localparam int HI  = MEM_ADDR_WIDTH + OFF;
    localparam int RW  = DATA_WIDTH + 2 + ID_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [0:(2**MEM_ADDR_WIDTH)-1];
    logic                  r_out_en;
    logic                  w_unused;

    assign w_unused = ^{i_awaddr[OFF-1:0], i_araddr[OFF-1:0]};

    // Keeps both address readies low while reset is held.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_out_en <= 1'b0;
        else         r_out_en <= 1'b1;
    end

    // ---------------- write engine ----------------
    t_wr_state                 r_wr_state, w_wr_next;
    logic [MEM_ADDR_WIDTH-1:0] r_w_idx;
    logic [LEN_WIDTH-1:0]      r_w_len, r_w_cnt;
    logic [ID_WIDTH-1:0]       r_w_id;
    logic                      r_w_err, r_w_proto;
    logic                      w_aw_hs, w_w_hs, w_w_lastcnt, w_aw_err;

    assign w_aw_err    = |i_awaddr[ADDR_WIDTH-1:HI];
    assign w_aw_hs     = i_awvalid && o_awready;
    assign w_w_hs      = i_wvalid && o_wready;
    assign w_w_lastcnt = (r_w_cnt == r_w_len);
    assign o_bid       = r_w_id;
    assign o_bresp     = (r_w_err || r_w_proto) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        w_wr_next = r_wr_state;
        o_awready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                o_awready = r_out_en;
                if (i_awvalid && r_out_en) w_wr_next = W_DATA;
            end
            W_DATA: begin
                o_wready = 1'b1;
                if (i_wvalid && (w_w_lastcnt || i_wlast)) w_wr_next = W_RESP;
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) w_wr_next = W_IDLE;
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_state <= W_IDLE;
            r_w_idx    <= '0;
            r_w_len    <= '0;
            r_w_cnt    <= '0;
            r_w_id     <= '0;
            r_w_err    <= 1'b0;
            r_w_proto  <= 1'b0;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_aw_hs) begin
                r_w_idx   <= i_awaddr[HI-1:OFF];
                r_w_len   <= i_awlen;
                r_w_id    <= i_awid;
                r_w_err   <= w_aw_err;
                r_w_proto <= 1'b0;
                r_w_cnt   <= '0;
            end
            if (w_w_hs) begin
                r_w_idx <= r_w_idx + 1'b1;
                r_w_cnt <= r_w_cnt + 1'b1;
                // wlast must coincide exactly with beat len
                if (i_wlast != w_w_lastcnt) r_w_proto <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_w_hs && !r_w_err) begin
            for (int b = 0; b < BPB; b++) begin
                if (i_wstrb[b]) r_mem[r_w_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    t_rd_state                 r_rd_state, w_rd_next;
    logic [MEM_ADDR_WIDTH-1:0] r_r_idx, w_rd_idx;
    logic [LEN_WIDTH-1:0]      r_r_len, r_r_cnt;
    logic [ID_WIDTH-1:0]       r_r_id, w_issue_id, r_pend_id;
    logic                      r_r_err, w_ar_err, w_issue_err, r_pend_err;
    logic                      w_issue, w_issue_last, r_pend, r_pend_last;
    logic                      w_ar_hs, w_pop, w_can_issue;
    logic [1:0]                w_sk_count;
    logic [DATA_WIDTH-1:0]     r_mem_q;
    logic [RW-1:0]             w_sk_in, w_sk_out;

    assign w_ar_err = |i_araddr[ADDR_WIDTH-1:HI];
    assign w_pop    = o_rvalid && i_rready;
    assign w_ar_hs  = i_arvalid && o_arready;
    // Buffer entries plus the read in flight, minus this cycle's pop, must leave a free slot.
    assign w_can_issue = ({1'b0, w_sk_count} + {2'b00, r_pend}) <= ({2'b00, w_pop} + 3'd1);

    always_comb begin
        w_rd_next    = r_rd_state;
        o_arready    = 1'b0;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        w_issue_err  = r_r_err;
        w_issue_id   = r_r_id;
        w_rd_idx     = r_r_idx;
        case (r_rd_state)
            R_IDLE: begin
                o_arready = r_out_en && w_can_issue;
                // Beat 0 is read in the handshake cycle; single-beat bursts never enter R_BURST.
                if (i_arvalid && o_arready) begin
                    w_issue      = 1'b1;
                    w_rd_idx     = i_araddr[HI-1:OFF];
                    w_issue_last = (i_arlen == '0);
                    w_issue_err  = w_ar_err;
                    w_issue_id   = i_arid;
                    if (i_arlen != '0) w_rd_next = R_BURST;
                end
            end
            R_BURST: begin
                if (w_can_issue) begin
                    w_issue      = 1'b1;
                    w_issue_last = (r_r_cnt == r_r_len);
                    if (r_r_cnt == r_r_len) w_rd_next = R_IDLE;
                end
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_state  <= R_IDLE;
            r_r_idx     <= '0;
            r_r_len     <= '0;
            r_r_cnt     <= '0;
            r_r_id      <= '0;
            r_r_err     <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_pend_err  <= 1'b0;
            r_pend_id   <= '0;
        end else begin
            r_rd_state  <= w_rd_next;
            r_pend      <= w_issue;
            r_pend_last <= w_issue_last;
            r_pend_err  <= w_issue_err;
            r_pend_id   <= w_issue_id;
            if (w_ar_hs) begin
                r_r_idx <= w_rd_idx + 1'b1;
                r_r_len <= i_arlen;
                r_r_id  <= i_arid;
                r_r_err <= w_ar_err;
                r_r_cnt <= {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            end else if (w_issue) begin
                r_r_idx <= r_r_idx + 1'b1;
                r_r_cnt <= r_r_cnt + 1'b1;
            end
        end
    end

    // Non-blocking read against the write block gives read-first on address collisions.
    always_ff @(posedge i_clk) begin
        if (w_issue) r_mem_q <= r_mem[w_rd_idx];
    end

    assign w_sk_in = {(r_pend_err ? {DATA_WIDTH{1'b0}} : r_mem_q),
                      (r_pend_err ? RESP_SLVERR : RESP_OKAY), r_pend_id, r_pend_last};
    assign {o_rdata, o_rresp, o_rid, o_rlast} = w_sk_out;

    axi_mem_skid_buffer #(.WIDTH(RW)) u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (r_pend),
        .i_data  (w_sk_in),
        .o_valid (o_rvalid),
        .i_ready (i_rready),
        .o_data  (w_sk_out),
        .o_count (w_sk_count)
    );

`ifdef AXI_MEM_RESPONDER_STATS_EN
    logic [31:0] r_wr_bursts, r_rd_bursts;
    logic [15:0] r_err_count;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    assign w_err_inc = {1'b0, o_bvalid && i_bready && (o_bresp == RESP_SLVERR)} +
                       {1'b0, w_pop && (o_rresp == RESP_SLVERR)};
    assign w_err_sum = {1'b0, r_err_count} + {15'd0, w_err_inc};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_bursts <= '0;
            r_rd_bursts <= '0;
            r_err_count <= '0;
        end else begin
            if (o_bvalid && i_bready && (r_wr_bursts != '1)) r_wr_bursts <= r_wr_bursts + 1'b1;
            if (w_pop && o_rlast && (r_rd_bursts != '1))     r_rd_bursts <= r_rd_bursts + 1'b1;
            r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign o_wr_bursts = r_wr_bursts;
    assign o_rd_bursts = r_rd_bursts;
    assign o_err_count = r_err_count;
`endif
endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed vector table, reset corner case, randomized bursts.
`timescale 1ns/1ps
module tb_axi_mem_responder;
  import axi_mem_responder_pkg::*;

  localparam int DW  = 256;
  localparam int AW  = 42;
  localparam int IW  = 8;
  localparam int BPB = 32;

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic           i_awvalid = 1'b0, o_awready;
  logic [AW-1:0]  i_awaddr = '0;
  logic [7:0]     i_awlen = '0;
  logic [IW-1:0]  i_awid = '0;
  logic           i_wvalid = 1'b0, o_wready;
  logic [DW-1:0]  i_wdata = '0;
  logic [BPB-1:0] i_wstrb = '0;
  logic           i_wlast = 1'b0;
  logic           o_bvalid, i_bready = 1'b0;
  logic [1:0]     o_bresp;
  logic [IW-1:0]  o_bid;
  logic           i_arvalid = 1'b0, o_arready;
  logic [AW-1:0]  i_araddr = '0;
  logic [7:0]     i_arlen = '0;
  logic [IW-1:0]  i_arid = '0;
  logic           o_rvalid, i_rready = 1'b0;
  logic [DW-1:0]  o_rdata;
  logic [1:0]     o_rresp;
  logic [IW-1:0]  o_rid;
  logic           o_rlast;
`ifdef AXI_MEM_RESPONDER_STATS_EN
  logic [31:0]    o_wr_bursts, o_rd_bursts;
  logic [15:0]    o_err_count;
`endif

  // Clock and reset
  always #5 i_clk = ~i_clk;

  axi_mem_responder dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
    .i_awlen(i_awlen), .i_awid(i_awid),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
    .i_wstrb(i_wstrb), .i_wlast(i_wlast),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp), .o_bid(o_bid),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
    .i_arlen(i_arlen), .i_arid(i_arid),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata),
    .o_rresp(o_rresp), .o_rid(o_rid), .o_rlast(o_rlast)
`ifdef AXI_MEM_RESPONDER_STATS_EN
    , .o_wr_bursts(o_wr_bursts), .o_rd_bursts(o_rd_bursts), .o_err_count(o_err_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: beat-addressed memory image and an expected-beat queue
  logic [DW-1:0]  model_mem [0:1023];
  logic [DW-1:0]  exp_q[$];
  logic [DW-1:0]  g_wdata [0:255];
  logic [BPB-1:0] g_wstrb [0:255];
  logic [DW-1:0]  g_last_rdata;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit is_err(input logic [AW-1:0] a);
    return (a >> 15) != 0;
  endfunction

  function automatic int base_beat(input logic [AW-1:0] a);
    return int'((a / 32) % 1024);
  endfunction

  task automatic model_write(input logic [AW-1:0] addr, input int nbeats);
    int idx;
    if (is_err(addr)) return;
    for (int b = 0; b < nbeats; b++) begin
      idx = (base_beat(addr) + b) % 1024;
      for (int k = 0; k < BPB; k++)
        if (g_wstrb[b][k]) model_mem[idx][k*8 +: 8] = g_wdata[b][k*8 +: 8];
    end
  endtask

  task automatic fill_data(input int dmode, input logic [BPB-1:0] strb, input int n);
    for (int b = 0; b < n; b++) begin
      case (dmode)
        0: g_wdata[b] = {32{8'hA5}};
        1: g_wdata[b] = DW'(b);
        3: g_wdata[b] = {32{8'h11}};
        4: g_wdata[b] = {32{8'hFF}};
        default: for (int w = 0; w < 8; w++) g_wdata[b][w*32 +: 32] = $urandom;
      endcase
      g_wstrb[b] = strb;
    end
  endtask

  // Driver: one write burst; wlast is driven on beat wlast_at (may be early or never)
  task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [IW-1:0] id,
                           input int wlast_at, input logic [1:0] exp_b, input string tag);
    int nb, guard;
    nb = ((wlast_at < len) ? wlast_at : len) + 1;
    i_awvalid = 1'b1; i_awaddr = addr; i_awlen = 8'(len); i_awid = id;
    guard = 0;
    while (!o_awready && guard < 50) begin @(negedge i_clk); guard++; end
    check({tag, " awready"}, DW'(o_awready), DW'(1));
    @(negedge i_clk);
    i_awvalid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      i_wvalid = 1'b1; i_wdata = g_wdata[b]; i_wstrb = g_wstrb[b]; i_wlast = (b == wlast_at);
      guard = 0;
      while (!o_wready && guard < 50) begin @(negedge i_clk); guard++; end
      if (!o_wready) check({tag, " wready"}, DW'(o_wready), DW'(1));
      @(negedge i_clk);
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;
    check({tag, " bvalid latency"}, DW'(o_bvalid), DW'(1));
    check({tag, " bresp"}, DW'(o_bresp), DW'(exp_b));
    check({tag, " bid"}, DW'(o_bid), DW'(id));
    i_bready = 1'b1;
    @(negedge i_clk);
    i_bready = 1'b0;
    check({tag, " bvalid drop"}, DW'(o_bvalid), DW'(0));
    model_write(addr, nb);
  endtask

  // Driver + scoreboard: one read burst; rmode 0=always ready, 1=toggle, 2=random
  task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [IW-1:0] id,
                          input int rmode, input logic [1:0] exp_r, input string tag);
    int got, guard, first_g, last_g;
    bit hold;
    logic [DW-1:0] h_data, exp_d;
    logic h_last;
    exp_q.delete();
    for (int b = 0; b <= len; b++)
      exp_q.push_back(is_err(addr) ? '0 : model_mem[(base_beat(addr) + b) % 1024]);
    i_arvalid = 1'b1; i_araddr = addr; i_arlen = 8'(len); i_arid = id;
    guard = 0;
    while (!o_arready && guard < 50) begin @(negedge i_clk); guard++; end
    check({tag, " arready"}, DW'(o_arready), DW'(1));
    @(negedge i_clk);
    i_arvalid = 1'b0;
    check({tag, " rvalid at N+1"}, DW'(o_rvalid), DW'(0));
    got = 0; guard = 0; hold = 0; first_g = 0; last_g = 0;
    while (got <= len && guard < 2000) begin
      if (guard == 1) check({tag, " rvalid at N+2"}, DW'(o_rvalid), DW'(1));
      case (rmode)
        0: i_rready = 1'b1;
        1: i_rready = (guard % 2 == 0);
        default: i_rready = 1'($urandom_range(0, 1));
      endcase
      if (hold) begin
        check({tag, " hold rvalid"}, DW'(o_rvalid), DW'(1));
        check({tag, " hold rdata"}, o_rdata, h_data);
        check({tag, " hold rlast"}, DW'(o_rlast), DW'(h_last));
      end
      if (o_rvalid && i_rready) begin
        exp_d = exp_q.pop_front();
        check({tag, " rdata"}, o_rdata, exp_d);
        check({tag, " rlast"}, DW'(o_rlast), DW'(got == len));
        check({tag, " rresp"}, DW'(o_rresp), DW'(exp_r));
        check({tag, " rid"}, DW'(o_rid), DW'(id));
        g_last_rdata = o_rdata;
        if (got == 0) first_g = guard;
        last_g = guard;
        got++;
        hold = 0;
      end else begin
        hold = o_rvalid; h_data = o_rdata; h_last = o_rlast;
      end
      @(negedge i_clk);
      guard++;
    end
    i_rready = 1'b0;
    check({tag, " beat count"}, DW'(got), DW'(len + 1));
    if (rmode == 0) check({tag, " back-to-back beats"}, DW'(last_g - first_g), DW'(len));
    check({tag, " no extra rvalid"}, DW'(o_rvalid), DW'(0));
  endtask

  typedef struct {
    logic [AW-1:0]  waddr;
    int             wlen;
    logic [IW-1:0]  wid;
    int             wlast_at;
    int             dmode;
    logic [BPB-1:0] strb;
    logic [1:0]     exp_b;
    logic [AW-1:0]  raddr;
    int             rlen;
    logic [IW-1:0]  rid;
    int             rmode;
    logic [1:0]     exp_r;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [BPB-1:0] rs;
    int len, rlen;
    bit err;

    vecs[0]  = '{42'h40,         0,  8'h11, 0,  0, '1,        RESP_OKAY,   42'h40,   0,  8'h11, 0, RESP_OKAY};
    vecs[1]  = '{42'h0,          15, 8'h22, 15, 1, '1,        RESP_OKAY,   42'h0,    15, 8'h22, 0, RESP_OKAY};
    vecs[2]  = '{42'h0,          15, 8'h23, 15, 1, '1,        RESP_OKAY,   42'h0,    15, 8'h23, 1, RESP_OKAY};
    vecs[3]  = '{42'h200,        0,  8'h33, 0,  4, '1,        RESP_OKAY,   42'h200,  0,  8'h33, 0, RESP_OKAY};
    vecs[4]  = '{42'h200,        0,  8'h34, 0,  3, 32'h0000000F, RESP_OKAY, 42'h200, 0,  8'h34, 0, RESP_OKAY};
    vecs[5]  = '{42'h8000,       3,  8'h55, 3,  2, '1,        RESP_SLVERR, 42'h8000, 0,  8'h56, 0, RESP_SLVERR};
    vecs[6]  = '{42'h7FE0,       3,  8'h66, 3,  2, '1,        RESP_OKAY,   42'h7FE0, 3,  8'h66, 2, RESP_OKAY};
    vecs[7]  = '{42'h200_0000_0040, 1, 8'h70, 1, 2, '1,       RESP_SLVERR, 42'h80,   3,  8'h71, 0, RESP_OKAY};
    vecs[8]  = '{42'h400,        5,  8'h77, 2,  2, '1,        RESP_SLVERR, 42'h400,  2,  8'h77, 1, RESP_OKAY};
    vecs[9]  = '{42'h600,        2,  8'h88, 9,  2, '1,        RESP_SLVERR, 42'h600,  2,  8'h89, 2, RESP_OKAY};
    vecs[10] = '{42'h45,         1,  8'h99, 1,  2, '1,        RESP_OKAY,   42'h40,   1,  8'h9A, 0, RESP_OKAY};

    // Reset state
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    check("reset awready", DW'(o_awready), DW'(0));
    check("reset arready", DW'(o_arready), DW'(0));
    check("reset wready",  DW'(o_wready),  DW'(0));
    check("reset bvalid",  DW'(o_bvalid),  DW'(0));
    check("reset rvalid",  DW'(o_rvalid),  DW'(0));
    check("reset bresp",   DW'(o_bresp),   DW'(0));
    check("reset rresp",   DW'(o_rresp),   DW'(0));
    check("reset bid",     DW'(o_bid),     DW'(0));
    check("reset rid",     DW'(o_rid),     DW'(0));
    check("reset rlast",   DW'(o_rlast),   DW'(0));
    check("reset rdata",   o_rdata,        '0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("post-reset awready", DW'(o_awready), DW'(1));
    check("post-reset arready", DW'(o_arready), DW'(1));

    // Directed vector table
    for (int v = 0; v < 11; v++) begin
      fill_data(vecs[v].dmode, vecs[v].strb, vecs[v].wlen + 1);
      axi_write(vecs[v].waddr, vecs[v].wlen, vecs[v].wid, vecs[v].wlast_at, vecs[v].exp_b,
                $sformatf("vec%0d wr", v));
      axi_read(vecs[v].raddr, vecs[v].rlen, vecs[v].rid, vecs[v].rmode, vecs[v].exp_r,
               $sformatf("vec%0d rd", v));
      if (v == 0) check("single write data", g_last_rdata, {32{8'hA5}});
      if (v == 4) check("partial strobe data", g_last_rdata, {{28{8'hFF}}, {4{8'h11}}});
    end

    // Reset in the middle of an 8-beat write burst at beat index 128
    fill_data(2, '1, 8);
    i_awvalid = 1'b1; i_awaddr = 42'h1000; i_awlen = 8'd7; i_awid = 8'hC3;
    @(negedge i_clk);
    i_awvalid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      i_wvalid = 1'b1; i_wdata = g_wdata[b]; i_wstrb = g_wstrb[b]; i_wlast = 1'b0;
      @(negedge i_clk);
    end
    i_wdata = g_wdata[3];
    i_reset = 1'b1;
    #1;
    check("midburst reset awready", DW'(o_awready), DW'(0));
    check("midburst reset wready",  DW'(o_wready),  DW'(0));
    check("midburst reset arready", DW'(o_arready), DW'(0));
    check("midburst reset bvalid",  DW'(o_bvalid),  DW'(0));
    check("midburst reset rvalid",  DW'(o_rvalid),  DW'(0));
    @(negedge i_clk);
    i_wvalid = 1'b0;
    i_reset = 1'b0;
    @(negedge i_clk);
    check("no bvalid after reset", DW'(o_bvalid), DW'(0));
    model_write(42'h1000, 3);
    axi_read(42'h1000, 2, 8'hC4, 0, RESP_OKAY, "reset preserved rd");
    fill_data(2, '1, 1);
    axi_write(42'h1020, 0, 8'hC5, 0, RESP_OKAY, "after reset wr");
    axi_read(42'h1020, 0, 8'hC5, 0, RESP_OKAY, "after reset rd");

    // Randomized bursts against the reference model
    for (int it = 0; it < 24; it++) begin
      len = $urandom_range(0, 15);
      err = ($urandom_range(0, 5) == 0);
      a = (AW'($urandom_range(0, 1023)) << 5) | AW'($urandom_range(0, 31));
      if (err) a = a | (AW'(1) << (15 + $urandom_range(0, 26)));
      fill_data(2, '1, len + 1);
      axi_write(a, len, 8'($urandom), len, is_err(a) ? RESP_SLVERR : RESP_OKAY,
                $sformatf("rnd%0d wr full", it));
      fill_data(2, '1, len + 1);
      for (int b = 0; b <= len; b++) begin
        rs = $urandom;
        g_wstrb[b] = rs;
      end
      axi_write(a, len, 8'($urandom), len, is_err(a) ? RESP_SLVERR : RESP_OKAY,
                $sformatf("rnd%0d wr strb", it));
      rlen = $urandom_range(0, len);
      axi_read(a, rlen, 8'($urandom), $urandom_range(0, 2), is_err(a) ? RESP_SLVERR : RESP_OKAY,
               $sformatf("rnd%0d rd", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
